a51_keystream_cipher: RTL and testbench



---
 rtl/a51_keystream_cipher.sv | 176 +++++++++++++++++
 tb/tb_a51_keystream_cipher.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/a51_keystream_cipher.sv
// A5/1 keystream byte assembler: packs serial keystream bits into bytes,
// XORs each with the matching message byte and buffers the result in a
// small FIFO for a ready/valid consumer.
module a51_keystream_cipher #(
  parameter int unsigned NUM_BYTES  = 28,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   ks_valid,
  input  logic                   ks_bit,
  input  logic [8*NUM_BYTES-1:0] msg_data,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4:0]             byte_index,
  output logic                   done,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state, state_n;
  logic          start_q;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    acc, acc_n;
  logic [IW-1:0] byte_index_n;
  logic          overflow_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [CW-1:0] count, count_n;
  logic [7:0]    out_data_n, head_n;
  logic          out_valid_n, done_n;
  logic [7:0]    msg_byte_c, push_data_c;
  logic          push_c, write_c, pop_c, flush_c, full_c, start_rise_c;

  // Select the message byte addressed by byte_index (zero once past the end).
  always_comb begin
    msg_byte_c = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (byte_index == IW'(k)) msg_byte_c = msg_data[8*k +: 8];
    end
  end

  // Next-state, datapath and FIFO bookkeeping.
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    acc_n        = acc;
    byte_index_n = byte_index;
    overflow_n   = overflow;
    wr_ptr_n     = wr_ptr;
    rd_ptr_n     = rd_ptr;
    count_n      = count;
    push_c       = 1'b0;
    flush_c      = 1'b0;
    push_data_c  = {acc[6:0], ks_bit} ^ msg_byte_c;
    start_rise_c = start & ~start_q;
    full_c       = (count == CW'(FIFO_DEPTH));

    case (state)
      S_IDLE: begin
        if (start_rise_c) begin
          state_n      = S_RUN;
          bit_cnt_n    = 3'd0;
          acc_n        = 8'h00;
          byte_index_n = '0;
          overflow_n   = 1'b0;
          flush_c      = 1'b1;
        end
      end
      S_RUN: begin
        if (!start) begin
          state_n = S_IDLE;
          flush_c = 1'b1;
        end else if (ks_valid) begin
          bit_cnt_n = bit_cnt + 3'd1;
          acc_n     = {acc[6:0], ks_bit};
          if (bit_cnt == 3'd7) begin
            push_c = 1'b1;
            if (byte_index < IW'(NUM_BYTES)) byte_index_n = byte_index + IW'(1);
            if (byte_index >= IW'(NUM_BYTES - 1)) state_n = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!start) begin
          state_n = S_IDLE;
          flush_c = 1'b1;
        end else if (count == '0) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    pop_c   = out_valid & out_ready & ~flush_c;
    write_c = push_c & (~full_c | pop_c);
    if (push_c && full_c && !pop_c) overflow_n = 1'b1;

    if (flush_c) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
    end else begin
      if (write_c) wr_ptr_n = wr_ptr + AW'(1);
      if (pop_c)   rd_ptr_n = rd_ptr + AW'(1);
      case ({write_c, pop_c})
        2'b10:   count_n = count + CW'(1);
        2'b01:   count_n = count - CW'(1);
        default: count_n = count;
      endcase
    end

    // Head after this edge: the new entry bypasses memory when it lands at the head.
    if (write_c && (wr_ptr == rd_ptr_n)) head_n = push_data_c;
    else                                 head_n = mem[rd_ptr_n];

    out_valid_n = (count_n != '0);
    out_data_n  = out_valid_n ? head_n : 8'h00;
    done_n      = (state_n == S_DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      bit_cnt    <= 3'd0;
      acc        <= 8'h00;
      byte_index <= '0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      start_q    <= start;
      bit_cnt    <= bit_cnt_n;
      acc        <= acc_n;
      byte_index <= byte_index_n;
      overflow   <= overflow_n;
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      count      <= count_n;
      out_data   <= out_data_n;
      out_valid  <= out_valid_n;
      done       <= done_n;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else if (write_c && !flush_c) begin
      mem[wr_ptr] <= push_data_c;
    end
  end

endmodule

// File: tb/tb_a51_keystream_cipher.sv
// Directed bench for a51_keystream_cipher: vector table plus corner-case sequences.
module tb_a51_keystream_cipher;

  localparam int unsigned NB = 28;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          ks_valid;
  logic          ks_bit;
  logic [8*NB-1:0] msg_data;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    byte_index;
  logic          done;
  logic          overflow;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic [7:0] m0, m1, k0, k1, e0, e1;
  } vec_t;
  vec_t vecs [5];

  a51_keystream_cipher #(.NUM_BYTES(NB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .ks_valid(ks_valid), .ks_bit(ks_bit),
    .msg_data(msg_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .byte_index(byte_index), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Feed the top n bits of b MSB first; out_ready is rdy_last on the eighth bit.
  task automatic send_bits(input logic [7:0] b, input int n, input bit rdy_pre, input bit rdy_last);
    for (int i = 0; i < n; i++) begin
      ks_valid  = 1'b1;
      ks_bit    = b[7-i];
      out_ready = (i == 7) ? rdy_last : rdy_pre;
      step();
    end
    ks_valid  = 1'b0;
    out_ready = rdy_pre;
  endtask

  task automatic start_session();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 50; i++) begin
      if (done) break;
      step();
    end
    check(name, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'hFF, 8'h0F, 8'h3C, 8'h3C, 8'hC3, 8'h33};
    vecs[1] = '{8'h00, 8'h00, 8'hA5, 8'h5A, 8'hA5, 8'h5A};
    vecs[2] = '{8'h12, 8'h34, 8'h00, 8'hFF, 8'h12, 8'hCB};
    vecs[3] = '{8'hAA, 8'h55, 8'hAA, 8'hAA, 8'h00, 8'hFF};
    vecs[4] = '{8'h80, 8'h01, 8'h01, 8'h80, 8'h81, 8'h81};

    reset = 1'b1; start = 1'b0; ks_valid = 1'b0; ks_bit = 1'b0;
    out_ready = 1'b0; msg_data = '0;
    #1 reset = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_byte_index", byte_index, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Two-byte vectors, consumer always ready, then abort.
    for (int v = 0; v < 5; v++) begin
      msg_data = '0;
      msg_data[7:0]  = vecs[v].m0;
      msg_data[15:8] = vecs[v].m1;
      out_ready = 1'b1;
      start_session();
      send_bits(vecs[v].k0, 8, 1'b1, 1'b1);
      check($sformatf("vec%0d_valid0", v), out_valid, 1);
      check($sformatf("vec%0d_byte0", v), out_data, vecs[v].e0);
      check($sformatf("vec%0d_idx1", v), byte_index, 1);
      send_bits(vecs[v].k1, 8, 1'b1, 1'b1);
      check($sformatf("vec%0d_byte1", v), out_data, vecs[v].e1);
      check($sformatf("vec%0d_idx2", v), byte_index, 2);
      start = 1'b0;
      step();
      check($sformatf("vec%0d_abort_valid", v), out_valid, 0);
    end

    // Full message of 0xA5 keystream over zero plaintext.
    msg_data = '0;
    out_ready = 1'b1;
    start_session();
    for (int b = 0; b < NB; b++) begin
      send_bits(8'hA5, 8, 1'b1, 1'b1);
      check($sformatf("a5_byte%0d", b), {out_valid, out_data}, {1'b1, 8'hA5});
    end
    wait_done("a5_done");
    check("a5_overflow", overflow, 0);
    check("a5_idx_sat", byte_index, NB);
    send_bits(8'hFF, 8, 1'b1, 1'b1);
    check("a5_ignore_valid", out_valid, 0);
    check("a5_ignore_idx", byte_index, NB);
    check("a5_done_hold", done, 1);
    start = 1'b0;
    step();
    check("a5_done_clear", done, 0);

    // Consumer stalled: four bytes buffered, the rest dropped.
    for (int k = 0; k < NB; k++) msg_data[8*k +: 8] = 8'(k);
    out_ready = 1'b0;
    start_session();
    for (int b = 0; b < NB; b++) begin
      send_bits(8'hFF, 8, 1'b0, 1'b0);
      if (b == 3) begin
        check("ovf_not_yet", overflow, 0);
        check("ovf_head_b3", {out_valid, out_data}, {1'b1, 8'hFF});
      end
      if (b == 4) check("ovf_set_b4", overflow, 1);
    end
    check("ovf_idx", byte_index, NB);
    check("ovf_sticky", overflow, 1);
    check("ovf_head_end", {out_valid, out_data}, {1'b1, 8'hFF});
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("ovf_drain%0d", j), {out_valid, out_data}, {1'b1, 8'hFF ^ 8'(j)});
      step();
    end
    check("ovf_empty", out_valid, 0);
    wait_done("ovf_done");
    check("ovf_sticky_done", overflow, 1);

    // Push into a full FIFO while the head is being accepted.
    out_ready = 1'b0;
    start_session();
    check("full_ovf_cleared", overflow, 0);
    for (int b = 0; b < 4; b++) send_bits(8'hFF, 8, 1'b0, 1'b0);
    send_bits(8'hFF, 8, 1'b0, 1'b1);
    check("full_no_drop", overflow, 0);
    check("full_head", {out_valid, out_data}, {1'b1, 8'hFE});
    check("full_idx", byte_index, 5);
    out_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      check($sformatf("full_drain%0d", j), {out_valid, out_data}, {1'b1, 8'hFF ^ 8'(j)});
      step();
    end
    check("full_occupancy4", out_valid, 0);
    start = 1'b0;
    step();

    // Abort after ten bits, then restart from byte 0.
    msg_data = '0;
    msg_data[7:0] = 8'h5A;
    out_ready = 1'b0;
    start_session();
    send_bits(8'hFF, 8, 1'b0, 1'b0);
    send_bits(8'hC0, 2, 1'b0, 1'b0);
    check("abort_pre_valid", {out_valid, out_data}, {1'b1, 8'hA5});
    start = 1'b0;
    step();
    check("abort_valid", out_valid, 0);
    check("abort_done", done, 0);
    start = 1'b1;
    step();
    check("restart_idx", byte_index, 0);
    check("restart_valid", out_valid, 0);
    send_bits(8'h0F, 8, 1'b1, 1'b1);
    check("restart_byte0", {out_valid, out_data}, {1'b1, 8'h55});
    check("restart_idx1", byte_index, 1);

    // Asynchronous reset in the middle of a byte.
    msg_data = '0;
    out_ready = 1'b0;
    start_session();
    for (int b = 0; b < 5; b++) send_bits(8'hFF, 8, 1'b0, 1'b0);
    send_bits(8'hFF, 5, 1'b0, 1'b0);
    check("pre_rst_ovf", overflow, 1);
    check("pre_rst_idx", byte_index, 5);
    #2;
    reset = 1'b0;
    start = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_idx", byte_index, 0);
    check("arst_done", done, 0);
    check("arst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b1;
    send_bits(8'hFF, 8, 1'b1, 1'b1);
    check("post_rst_idle", out_valid, 0);
    check("post_rst_idx", byte_index, 0);
    start_session();
    send_bits(8'h3C, 8, 1'b1, 1'b1);
    check("post_rst_byte", {out_valid, out_data}, {1'b1, 8'h3C});
    check("post_rst_idx1", byte_index, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
